// File: rtl/classical_ctrl_pkg.sv
// rtl/classical_ctrl_pkg.sv - opcodes, instruction field positions, FSM states and encodings
package classical_ctrl_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_OR    = 6'h04;
  localparam logic [5:0] OP_XOR   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h06;
  localparam logic [5:0] OP_LD    = 6'h07;
  localparam logic [5:0] OP_ST    = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h09;
  localparam logic [5:0] OP_BNE   = 6'h0A;
  localparam logic [5:0] OP_JMP   = 6'h0B;
  localparam logic [5:0] OP_QOP   = 6'h0C;
  localparam logic [5:0] OP_QTIME = 6'h0D;
  localparam logic [5:0] OP_MEAS  = 6'h0E;
  localparam logic [5:0] OP_MEASW = 6'h0F;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OP_LSB   = 58;
  localparam int RD_LSB   = 53;
  localparam int RS1_LSB  = 48;
  localparam int RS2_LSB  = 43;
  localparam int TSEL_BIT = 42;

  localparam logic [1:0] QW_NONE = 2'b00;
  localparam logic [1:0] QW_GATE = 2'b01;
  localparam logic [1:0] QW_MEAS = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALTED
  } state_e;

  function automatic logic [63:0] sext_imm(input logic [31:0] imm);
    return {{32{imm[31]}}, imm};
  endfunction

endpackage

// File: rtl/ctrl_alu.sv
// rtl/ctrl_alu.sv - combinational 64-bit ALU with equality compare for branches
module ctrl_alu
  import classical_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] result_o,
  output logic        eq_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: ;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/classical_controller.sv
// rtl/classical_controller.sv - multi-cycle 64-bit classical control processor (FSM + regfile)
module classical_controller
  import classical_ctrl_pkg::*;
#(
  parameter int AW   = 11,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   i_q_measurement,
  input  logic [63:0]   start_sig,
  input  logic [63:0]   reg1,
  input  logic [63:0]   reg2,
  output logic          q_time_write,
  output logic          q_time_sel,
  output logic [63:0]   q_time_reg,
  output logic [1:0]    q_reg_write,
  output logic [63:0]   q_inst,
  output logic [5:0]    meas_rd_addr,
  output logic          pram_en,
  output logic          pram_rd_en,
  output logic [AW-1:0] pram_addr,
  input  logic [63:0]   instruction,
  output logic          inverted_clk,
  output logic          dram_en,
  output logic          dram_rd_en,
  output logic          dram_wr_en,
  output logic [AW-1:0] dram_addr,
  output logic [63:0]   dram_din,
  input  logic [63:0]   data_read,
  output logic          end_sig
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [63:0]   ir_q, ir_d;
  logic [63:0]   regs_q [NREG];
  logic          start_prev_q;

  logic          q_time_write_q, q_time_write_d;
  logic          q_time_sel_q, q_time_sel_d;
  logic [63:0]   q_time_reg_q, q_time_reg_d;
  logic [1:0]    q_reg_write_q, q_reg_write_d;
  logic [63:0]   q_inst_q, q_inst_d;
  logic [5:0]    meas_rd_addr_q, meas_rd_addr_d;

  logic [5:0]    op;
  logic [4:0]    rd, rs1, rs2;
  logic          tsel;
  logic [63:0]   imm, rs1_val, rs2_val, rd_val;

  logic [2:0]    alu_op;
  logic [63:0]   alu_b, alu_res;
  logic          alu_eq;

  logic          load_start, rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          mem_rd, mem_wr;
  logic          unused_bits;

  assign op      = ir_q[OP_LSB +: 6];
  assign rd      = ir_q[RD_LSB +: 5];
  assign rs1     = ir_q[RS1_LSB +: 5];
  assign rs2     = ir_q[RS2_LSB +: 5];
  assign tsel    = ir_q[TSEL_BIT];
  assign imm     = sext_imm(ir_q[31:0]);
  assign rs1_val = regs_q[rs1];
  assign rs2_val = regs_q[rs2];
  assign rd_val  = regs_q[rd];
  assign pc_inc  = pc_q + {{(AW-1){1'b0}}, 1'b1};

  assign unused_bits = ^{start_sig[63:1], ir_q[41:32]};

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm;
    case (op)
      OP_ADD:         alu_b = rs2_val;
      OP_SUB:         begin alu_op = ALU_SUB; alu_b = rs2_val; end
      OP_AND:         begin alu_op = ALU_AND; alu_b = rs2_val; end
      OP_OR:          begin alu_op = ALU_OR;  alu_b = rs2_val; end
      OP_XOR:         begin alu_op = ALU_XOR; alu_b = rs2_val; end
      OP_BEQ, OP_BNE: alu_b = rs2_val;
      default: ;
    endcase
  end

  ctrl_alu u_alu (
    .op_i     (alu_op),
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .result_o (alu_res),
    .eq_o     (alu_eq)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    load_start     = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = rd;
    rf_wdata       = alu_res;
    q_time_write_d = 1'b0;
    q_reg_write_d  = QW_NONE;
    q_time_sel_d   = q_time_sel_q;
    q_time_reg_d   = q_time_reg_q;
    q_inst_d       = q_inst_q;
    meas_rd_addr_d = meas_rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_sig[0]) begin
          load_start = 1'b1;
          pc_d       = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: rf_we = 1'b1;
          OP_LD, OP_ST: state_d = ST_MEM;
          OP_BEQ: if (alu_eq)  pc_d = imm[AW-1:0];
          OP_BNE: if (!alu_eq) pc_d = imm[AW-1:0];
          OP_JMP: pc_d = imm[AW-1:0];
          OP_QOP: begin
            q_inst_d      = rs1_val;
            q_reg_write_d = imm[1:0];
          end
          OP_QTIME: begin
            q_time_reg_d   = alu_res;
            q_time_sel_d   = tsel;
            q_time_write_d = 1'b1;
          end
          OP_MEAS: begin
            meas_rd_addr_d = imm[5:0];
            rf_we          = 1'b1;
            rf_wdata       = {63'b0, i_q_measurement[imm[5:0]]};
          end
          OP_MEASW: begin
            rf_we    = 1'b1;
            rf_wdata = i_q_measurement;
          end
          OP_HALT: begin
            state_d = ST_HALTED;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        state_d = ST_FETCH;
        if (op == OP_LD) begin
          rf_we    = 1'b1;
          rf_wdata = data_read;
        end
      end
      ST_HALTED: begin
        // Only a fresh 0->1 edge on the run bit restarts a finished program
        if (start_sig[0] && !start_prev_q) begin
          load_start = 1'b1;
          pc_d       = '0;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      ir_q           <= '0;
      start_prev_q   <= 1'b0;
      q_time_write_q <= 1'b0;
      q_time_sel_q   <= 1'b0;
      q_time_reg_q   <= '0;
      q_reg_write_q  <= QW_NONE;
      q_inst_q       <= '0;
      meas_rd_addr_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      start_prev_q   <= start_sig[0];
      q_time_write_q <= q_time_write_d;
      q_time_sel_q   <= q_time_sel_d;
      q_time_reg_q   <= q_time_reg_d;
      q_reg_write_q  <= q_reg_write_d;
      q_inst_q       <= q_inst_d;
      meas_rd_addr_q <= meas_rd_addr_d;
      if (load_start) begin
        regs_q[1] <= reg1;
        regs_q[2] <= reg2;
      end
      if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // dram samples on the falling edge, so a reset raised mid-MEM must squash the strobe at once
  assign mem_rd     = (state_q == ST_MEM) && (op == OP_LD);
  assign mem_wr     = (state_q == ST_MEM) && (op == OP_ST);
  assign dram_en    = (mem_rd || mem_wr) && !rst;
  assign dram_rd_en = mem_rd && !rst;
  assign dram_wr_en = mem_wr && !rst;
  assign dram_addr  = (mem_rd || mem_wr) ? alu_res[AW-1:0] : '0;
  assign dram_din   = mem_wr ? rd_val : '0;

  assign pram_en      = (state_q == ST_FETCH);
  assign pram_rd_en   = (state_q == ST_FETCH);
  assign pram_addr    = pc_q;
  assign inverted_clk = ~clk;
  assign end_sig      = (state_q == ST_HALTED);

  assign q_time_write = q_time_write_q;
  assign q_time_sel   = q_time_sel_q;
  assign q_time_reg   = q_time_reg_q;
  assign q_reg_write  = q_reg_write_q;
  assign q_inst       = q_inst_q;
  assign meas_rd_addr = meas_rd_addr_q;

endmodule

// File: tb/tb_classical_controller.sv
// tb/tb_classical_controller.sv - directed bench with pram/dram models and pulse monitors
module tb_classical_controller;

  localparam int AW = 11;

  localparam logic [5:0] T_ADDI = 6'h06, T_SUB = 6'h02, T_XOR = 6'h05, T_LD = 6'h07;
  localparam logic [5:0] T_ST = 6'h08, T_BEQ = 6'h09, T_BNE = 6'h0A, T_QOP = 6'h0C;
  localparam logic [5:0] T_QTIME = 6'h0D, T_MEAS = 6'h0E, T_MEASW = 6'h0F, T_HALT = 6'h3F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   i_q_measurement = '0, start_sig = '0, reg1 = '0, reg2 = '0;
  logic          q_time_write, q_time_sel;
  logic [63:0]   q_time_reg, q_inst;
  logic [1:0]    q_reg_write;
  logic [5:0]    meas_rd_addr;
  logic          pram_en, pram_rd_en, inverted_clk, dram_en, dram_rd_en, dram_wr_en, end_sig;
  logic [AW-1:0] pram_addr, dram_addr;
  logic [63:0]   instruction = '0, data_read = '0, dram_din;

  logic [63:0]   pmem [0:2047];
  logic [63:0]   dmem [0:2047];

  int n_checks = 0, n_errs = 0;
  int fn = 0, qn = 0, tn = 0, q_wide = 0, t_wide = 0, wr_cnt = 0;
  logic [AW-1:0] fa [64];
  logic [63:0]   qv [64], tv [64];
  logic [1:0]    qk [64];
  logic          ts [64];
  logic          prev_q = 1'b0, prev_t = 1'b0;
  logic [AW-1:0] wr_addr_last = '0;
  logic [63:0]   wr_din_last = '0;

  classical_controller #(.AW(AW), .NREG(32)) dut (
    .clk(clk), .rst(rst), .i_q_measurement(i_q_measurement), .start_sig(start_sig),
    .reg1(reg1), .reg2(reg2), .q_time_write(q_time_write), .q_time_sel(q_time_sel),
    .q_time_reg(q_time_reg), .q_reg_write(q_reg_write), .q_inst(q_inst),
    .meas_rd_addr(meas_rd_addr), .pram_en(pram_en), .pram_rd_en(pram_rd_en),
    .pram_addr(pram_addr), .instruction(instruction), .inverted_clk(inverted_clk),
    .dram_en(dram_en), .dram_rd_en(dram_rd_en), .dram_wr_en(dram_wr_en),
    .dram_addr(dram_addr), .dram_din(dram_din), .data_read(data_read), .end_sig(end_sig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pram_en && pram_rd_en) instruction <= pmem[pram_addr];

  always @(posedge inverted_clk) begin
    if (dram_en && dram_wr_en) begin
      dmem[dram_addr] <= dram_din;
      wr_cnt++;
      wr_addr_last = dram_addr;
      wr_din_last  = dram_din;
    end
    if (dram_en && dram_rd_en) data_read <= dmem[dram_addr];
  end

  always @(negedge clk) begin
    if (pram_en && pram_rd_en) begin
      if (fn < 64) fa[fn] = pram_addr;
      fn++;
    end
    if (q_reg_write != 2'b00) begin
      if (prev_q) q_wide++;
      if (qn < 64) begin qv[qn] = q_inst; qk[qn] = q_reg_write; end
      qn++;
    end
    prev_q = (q_reg_write != 2'b00);
    if (q_time_write) begin
      if (prev_t) t_wide++;
      if (tn < 64) begin tv[tn] = q_time_reg; ts[tn] = q_time_sel; end
      tn++;
    end
    prev_t = q_time_write;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic tsel, input logic [31:0] imm);
    logic [63:0] w;
    w = '0;
    w[63:58] = op; w[57:53] = rd; w[52:48] = rs1; w[47:43] = rs2; w[42] = tsel; w[31:0] = imm;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_sig = '0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) pmem[i] = '0;
  endtask

  // The first tick is the edge that samples start, so a restart from HALTED works too
  task automatic run_prog(input int budget, output int cycles);
    cycles = 0;
    start_sig = 64'h1;
    do begin
      tick(1);
      cycles++;
    end while (cycles < budget && !end_sig);
  endtask

  int cyc, fb, qb, tb_i, wb;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Program A: ADDI R3,R0,5 ; HALT
    clear_prog();
    pmem[0] = enc(T_ADDI, 5'd3, 5'd0, 5'd0, 1'b0, 32'd5);
    pmem[1] = enc(T_HALT, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    do_reset();
    check("rst_end_sig", end_sig, 0);
    check("rst_pram_en", pram_en, 0);
    check("rst_pram_addr", pram_addr, 0);
    check("rst_dram_en", {dram_en, dram_rd_en, dram_wr_en}, 0);
    check("rst_q_reg_write", q_reg_write, 0);
    check("rst_q_inst", q_inst, 0);
    check("rst_q_time", {q_time_write, q_time_sel}, 0);
    check("rst_q_time_reg", q_time_reg, 0);
    check("rst_meas_addr", meas_rd_addr, 0);
    check("rst_inverted_clk", inverted_clk, 1'b0);

    fb = fn;
    start_sig = 64'hFFFF_FFFF_FFFF_FFFE;
    tick(4);
    check("start_bit0_only", fn - fb, 0);

    fb = fn;
    run_prog(20, cyc);
    check("a_end_sig", end_sig, 1);
    // start edge + 2 instructions x 3 cycles
    check("a_halt_latency", cyc, 7);
    tick(3);
    check("a_pram_addr_stop", pram_addr, 1);
    check("a_fetch_count", fn - fb, 2);
    check("a_still_halted", end_sig, 1);

    // Program B: memory, quantum ops, measurement, R0 and wraparound arithmetic
    clear_prog();
    pmem[0]  = enc(T_ADDI,  5'd3, 5'd0, 5'd0, 1'b0, 32'd5);
    pmem[1]  = enc(T_ST,    5'd3, 5'd0, 5'd0, 1'b0, 32'd4);
    pmem[2]  = enc(T_LD,    5'd4, 5'd0, 5'd0, 1'b0, 32'd4);
    pmem[3]  = enc(T_QOP,   5'd0, 5'd4, 5'd0, 1'b0, 32'd1);
    pmem[4]  = enc(T_SUB,   5'd8, 5'd0, 5'd3, 1'b0, 32'd0);
    pmem[5]  = enc(T_QOP,   5'd0, 5'd8, 5'd0, 1'b0, 32'd1);
    pmem[6]  = enc(T_QTIME, 5'd0, 5'd3, 5'd0, 1'b1, 32'd100);
    pmem[7]  = enc(T_MEAS,  5'd5, 5'd0, 5'd0, 1'b0, 32'd3);
    pmem[8]  = enc(T_QOP,   5'd0, 5'd5, 5'd0, 1'b0, 32'd2);
    pmem[9]  = enc(T_MEASW, 5'd6, 5'd0, 5'd0, 1'b0, 32'd0);
    pmem[10] = enc(T_ADDI,  5'd0, 5'd0, 5'd0, 1'b0, 32'd7);
    pmem[11] = enc(T_XOR,   5'd7, 5'd6, 5'd3, 1'b0, 32'd0);
    pmem[12] = enc(T_QOP,   5'd0, 5'd7, 5'd0, 1'b0, 32'd1);
    pmem[13] = enc(T_QOP,   5'd0, 5'd0, 5'd0, 1'b0, 32'd1);
    pmem[14] = enc(T_ADDI,  5'd9, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFF);
    pmem[15] = enc(T_QOP,   5'd0, 5'd9, 5'd0, 1'b0, 32'd1);
    pmem[16] = enc(T_HALT,  5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    i_q_measurement = 64'h8;
    do_reset();
    qb = qn; tb_i = tn; wb = wr_cnt;
    run_prog(100, cyc);
    check("b_end_sig", end_sig, 1);
    check("b_dram_writes", wr_cnt - wb, 1);
    check("b_dram_wr_addr", wr_addr_last, 4);
    check("b_dram_wr_din", wr_din_last, 5);
    check("b_qop_count", qn - qb, 6);
    check("b_qop_ld_r4", qv[qb + 0], 64'd5);
    check("b_qop_ld_kind", qk[qb + 0], 2'b01);
    check("b_qop_sub_wrap", qv[qb + 1], 64'hFFFF_FFFF_FFFF_FFFB);
    check("b_qop_meas_r5", qv[qb + 2], 64'd1);
    check("b_qop_meas_kind", qk[qb + 2], 2'b10);
    check("b_qop_xor_r7", qv[qb + 3], 64'hD);
    check("b_qop_r0_zero", qv[qb + 4], 64'd0);
    check("b_qop_sext_imm", qv[qb + 5], 64'hFFFF_FFFF_FFFF_FFFF);
    check("b_qop_pulse_1cyc", q_wide, 0);
    check("b_qtime_count", tn - tb_i, 1);
    check("b_qtime_val", tv[tb_i], 64'd105);
    check("b_qtime_sel", ts[tb_i], 1);
    check("b_qtime_pulse_1cyc", t_wide, 0);
    check("b_qtime_hold", q_time_reg, 64'd105);
    check("b_meas_rd_addr", meas_rd_addr, 3);
    check("b_q_inst_hold", q_inst, 64'hFFFF_FFFF_FFFF_FFFF);

    // Program C: branches, then restart from HALTED with a new reg2
    clear_prog();
    pmem[0]  = enc(T_BEQ,  5'd0, 5'd1, 5'd2, 1'b0, 32'd10);
    pmem[1]  = enc(T_BNE,  5'd0, 5'd1, 5'd2, 1'b0, 32'd12);
    pmem[10] = enc(T_HALT, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    pmem[12] = enc(T_HALT, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    reg1 = 64'd7; reg2 = 64'd7;
    do_reset();
    fb = fn;
    run_prog(30, cyc);
    check("c_beq_end", end_sig, 1);
    check("c_beq_fetch_n", fn - fb, 2);
    check("c_beq_target", fa[fb + 1], 10);
    check("c_beq_pc", pram_addr, 10);
    start_sig = '0;
    reg2 = 64'd8;
    tick(1);
    fb = fn;
    run_prog(30, cyc);
    check("c_restart_end", end_sig, 1);
    check("c_restart_fetch_n", fn - fb, 3);
    check("c_restart_pc0", fa[fb + 0], 0);
    check("c_beq_not_taken", fa[fb + 1], 1);
    check("c_bne_taken", fa[fb + 2], 12);

    // Program D: reset raised while a store sits in MEM
    clear_prog();
    pmem[0] = enc(T_ADDI,  5'd3, 5'd0, 5'd0, 1'b0, 32'd5);
    pmem[1] = enc(T_QOP,   5'd0, 5'd3, 5'd0, 1'b0, 32'd1);
    pmem[2] = enc(T_QTIME, 5'd0, 5'd3, 5'd0, 1'b0, 32'd100);
    pmem[3] = enc(T_MEAS,  5'd5, 5'd0, 5'd0, 1'b0, 32'd3);
    pmem[4] = enc(T_ST,    5'd3, 5'd0, 5'd0, 1'b0, 32'd6);
    pmem[5] = enc(T_HALT,  5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    do_reset();
    start_sig = 64'h1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (dram_wr_en) found = 1'b1;
    end
    check("d_store_reached", found, 1);
    check("d_pre_q_inst", q_inst, 5);
    wb = wr_cnt;
    rst = 1'b1;
    start_sig = '0;
    #1;
    check("d_wr_en_squashed", dram_wr_en, 0);
    tick(1);
    check("d_no_dram_write", wr_cnt - wb, 0);
    check("d_q_inst", q_inst, 0);
    check("d_q_time_reg", q_time_reg, 0);
    check("d_meas_addr", meas_rd_addr, 0);
    check("d_pram", {pram_en, pram_rd_en, pram_addr}, 0);
    check("d_dram", {dram_en, dram_rd_en, dram_wr_en, dram_addr}, 0);
    check("d_end_sig", end_sig, 0);
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
